// File: rtl/alarm_pulse_decoder.sv
// Receive-side decoder for the one-hot buzzer lines: validates pulse shape and width,
// emits per-pulse events, keeps saturating per-channel counts and sticky error flags.
module alarm_pulse_decoder #(
   parameter int unsigned PULSE_LEN = 31,
   parameter int unsigned TOL       = 1,
   parameter int unsigned LEN_W     = 6,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [2:0]       buz,
   input  logic             clr,
   input  logic [1:0]       rd_sel,
   output logic [CNT_W-1:0] rd_data,
   output logic             event_valid,
   output logic [1:0]       event_code,
   output logic [LEN_W-1:0] event_len,
   output logic [2:0]       alarm_latched,
   output logic             err_multi,
   output logic             err_len
);

   localparam logic [LEN_W-1:0] LEN_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int unsigned      LEN_LO  = PULSE_LEN - TOL;
   localparam int unsigned      LEN_HI  = PULSE_LEN + TOL;

   typedef enum logic [1:0] {StIdle, StMeasure, StWaitLow} state_t;

   state_t           state_q, state_d;
   logic [1:0]       ch_q, ch_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];
   logic [CNT_W-1:0] total_q, total_d;
   logic [CNT_W-1:0] rd_data_q, rd_mux;
   logic [2:0]       alarm_q;
   logic             err_multi_q, err_len_q;
   logic             ev_valid_q;
   logic [1:0]       ev_code_q;
   logic [LEN_W-1:0] ev_len_q;

   logic             ev_fire, set_multi, set_len;
   logic             buz_onehot, len_ok;
   logic [1:0]       buz_idx;
   logic [2:0]       ch_hot;

   assign buz_onehot = (buz == 3'b001) || (buz == 3'b010) || (buz == 3'b100);
   assign buz_idx    = buz[0] ? 2'd0 : (buz[1] ? 2'd1 : 2'd2);
   assign ch_hot     = 3'b001 << ch_q;
   // A saturated length is compared as-is, so it only passes if the window reaches LEN_MAX.
   assign len_ok     = (32'(len_q) >= LEN_LO) && (32'(len_q) <= LEN_HI);

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      len_d     = len_q;
      ev_fire   = 1'b0;
      set_multi = 1'b0;
      set_len   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (buz == 3'b000) begin
               state_d = StIdle;
            end else if (buz_onehot) begin
               state_d = StMeasure;
               ch_d    = buz_idx;
               len_d   = LEN_W'(1);
            end else begin
               set_multi = 1'b1;
               state_d   = StWaitLow;
            end
         end
         StMeasure: begin
            if (buz == ch_hot) begin
               len_d = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);
            end else if (buz == 3'b000) begin
               state_d = StIdle;
               ev_fire = len_ok;
               set_len = !len_ok;
            end else begin
               set_multi = 1'b1;
               state_d   = StWaitLow;
            end
         end
         StWaitLow: begin
            if (buz == 3'b000) state_d = StIdle;
         end
         default: state_d = StWaitLow;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i];
         if (ev_fire && (ch_q == 2'(i)) && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      total_d = total_q;
      if (ev_fire && (total_q != CNT_MAX)) total_d = total_q + CNT_W'(1);
   end

   // Readback samples the counters before this edge's update.
   always_comb begin
      rd_mux = total_q;
      case (rd_sel)
         2'd0:    rd_mux = cnt_q[0];
         2'd1:    rd_mux = cnt_q[1];
         2'd2:    rd_mux = cnt_q[2];
         default: rd_mux = total_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StWaitLow;
         ch_q        <= '0;
         len_q       <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
         total_q     <= '0;
         rd_data_q   <= '0;
         alarm_q     <= '0;
         err_multi_q <= 1'b0;
         err_len_q   <= 1'b0;
         ev_valid_q  <= 1'b0;
         ev_code_q   <= '0;
         ev_len_q    <= '0;
      end else if (ena) begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         len_q      <= len_d;
         rd_data_q  <= rd_mux;
         ev_valid_q <= ev_fire;
         if (ev_fire) begin
            ev_code_q <= ch_q + 2'd1;
            ev_len_q  <= len_q;
         end
         if (clr) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            total_q     <= '0;
            alarm_q     <= '0;
            err_multi_q <= 1'b0;
            err_len_q   <= 1'b0;
         end else begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            total_q <= total_d;
            if (ev_fire) alarm_q <= alarm_q | ch_hot;
            if (set_multi) err_multi_q <= 1'b1;
            if (set_len) err_len_q <= 1'b1;
         end
      end else begin
         ev_valid_q <= 1'b0;
      end
   end

   assign rd_data       = rd_data_q;
   assign event_valid   = ev_valid_q;
   assign event_code    = ev_code_q;
   assign event_len     = ev_len_q;
   assign alarm_latched = alarm_q;
   assign err_multi     = err_multi_q;
   assign err_len       = err_len_q;

endmodule

// File: tb/tb_alarm_pulse_decoder.sv
// Directed bench for alarm_pulse_decoder: a pulse-vector table plus hand-written
// sequences for reset, multi-hot, clear, enable and saturation corners.
module tb_alarm_pulse_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [2:0] buz;
   logic       clr;
   logic [1:0] rd_sel;
   logic [7:0] rd_data;
   logic       event_valid;
   logic [1:0] event_code;
   logic [5:0] event_len;
   logic [2:0] alarm_latched;
   logic       err_multi;
   logic       err_len;

   int checks = 0;
   int errors = 0;
   int ev_seen = 0;

   typedef struct {
      logic [2:0] pat;
      int         width;
      logic       exp_ev;
      logic [1:0] exp_code;
      logic [5:0] exp_len;
      logic       exp_err_len;
   } vec_t;

   vec_t vecs[7];

   alarm_pulse_decoder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .buz          (buz),
      .clr          (clr),
      .rd_sel       (rd_sel),
      .rd_data      (rd_data),
      .event_valid  (event_valid),
      .event_code   (event_code),
      .event_len    (event_len),
      .alarm_latched(alarm_latched),
      .err_multi    (err_multi),
      .err_len      (err_len)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (event_valid) ev_seen++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // High for width sampled cycles, then one low cycle; returns just after that low edge.
   task automatic pulse(input logic [2:0] pat, input int width);
      buz = pat;
      repeat (width) tick();
      buz = 3'b000;
      tick();
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic rd(input logic [1:0] sel, output logic [7:0] val);
      rd_sel = sel;
      tick();
      val = rd_data;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_rd"}, 32'(rd_data), 32'd0);
      check({name, "_ev"}, 32'(event_valid), 32'd0);
      check({name, "_code"}, 32'(event_code), 32'd0);
      check({name, "_len"}, 32'(event_len), 32'd0);
      check({name, "_alarm"}, 32'(alarm_latched), 32'd0);
      check({name, "_emulti"}, 32'(err_multi), 32'd0);
      check({name, "_elen"}, 32'(err_len), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      logic [5:0] len_before;

      vecs[0] = '{3'b001, 30, 1'b1, 2'd1, 6'd30, 1'b0};
      vecs[1] = '{3'b010, 32, 1'b1, 2'd2, 6'd32, 1'b0};
      vecs[2] = '{3'b100, 29, 1'b0, 2'd0, 6'd0,  1'b1};
      vecs[3] = '{3'b100, 33, 1'b0, 2'd0, 6'd0,  1'b1};
      vecs[4] = '{3'b001, 70, 1'b0, 2'd0, 6'd0,  1'b1};
      vecs[5] = '{3'b100, 31, 1'b1, 2'd3, 6'd31, 1'b0};
      vecs[6] = '{3'b010, 1,  1'b0, 2'd0, 6'd0,  1'b1};

      rst_n = 1'b0; ena = 1'b1; buz = 3'b000; clr = 1'b0; rd_sel = 2'd0;
      #12;
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) tick();

      // Nominal ch1 pulse.
      ev_seen = 0;
      pulse(3'b010, 31);
      check("nom_ev", 32'(event_valid), 32'd1);
      check("nom_code", 32'(event_code), 32'd2);
      check("nom_len", 32'(event_len), 32'd31);
      check("nom_alarm", 32'(alarm_latched), 32'b010);
      tick();
      check("nom_ev_off", 32'(event_valid), 32'd0);
      check("nom_ev_once", 32'(ev_seen), 32'd1);
      rd(2'd1, v);
      check("nom_cnt1", 32'(v), 32'd1);

      // Table of single pulses, each from a cleared state.
      foreach (vecs[i]) begin
         do_clr();
         ev_seen = 0;
         pulse(vecs[i].pat, vecs[i].width);
         check($sformatf("vec%0d_ev", i), 32'(event_valid), 32'(vecs[i].exp_ev));
         if (vecs[i].exp_ev) begin
            check($sformatf("vec%0d_code", i), 32'(event_code), 32'(vecs[i].exp_code));
            check($sformatf("vec%0d_len", i), 32'(event_len), 32'(vecs[i].exp_len));
         end
         check($sformatf("vec%0d_errlen", i), 32'(err_len), 32'(vecs[i].exp_err_len));
         tick();
         check($sformatf("vec%0d_count", i), 32'(ev_seen), 32'(vecs[i].exp_ev));
      end

      // Reset asserted mid-pulse, released while a pulse is still in progress.
      do_clr();
      pulse(3'b010, 31);
      rd_sel = 2'd1;
      buz = 3'b010;
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      #1 rst_n = 1'b1;
      ev_seen = 0;
      repeat (10) tick();
      buz = 3'b000;
      repeat (3) tick();
      check("rstrel_noev", 32'(ev_seen), 32'd0);
      check("rstrel_elen", 32'(err_len), 32'd0);
      check("rstrel_emulti", 32'(err_multi), 32'd0);

      // Short pulse then a long-but-in-tolerance pulse on ch0, back to back.
      ev_seen = 0;
      pulse(3'b001, 20);
      check("short_elen", 32'(err_len), 32'd1);
      check("short_noev", 32'(event_valid), 32'd0);
      pulse(3'b001, 32);
      check("long_ev", 32'(event_valid), 32'd1);
      check("long_code", 32'(event_code), 32'd1);
      check("long_len", 32'(event_len), 32'd32);
      rd(2'd0, v);
      check("long_cnt0", 32'(v), 32'd1);
      check("long_evcount", 32'(ev_seen), 32'd1);

      // Multi-hot from idle, then a valid ch2 pulse.
      do_clr();
      ev_seen = 0;
      buz = 3'b011;
      repeat (5) tick();
      buz = 3'b000;
      tick();
      check("mh_emulti", 32'(err_multi), 32'd1);
      check("mh_noev", 32'(ev_seen), 32'd0);
      pulse(3'b100, 31);
      check("mh_next_ev", 32'(event_valid), 32'd1);
      check("mh_next_code", 32'(event_code), 32'd3);
      rd(2'd2, v);
      check("mh_cnt2", 32'(v), 32'd1);

      // Channel change mid-pulse.
      do_clr();
      ev_seen = 0;
      buz = 3'b001;
      repeat (10) tick();
      buz = 3'b100;
      repeat (10) tick();
      buz = 3'b000;
      repeat (2) tick();
      check("chg_emulti", 32'(err_multi), 32'd1);
      check("chg_noev", 32'(ev_seen), 32'd0);
      check("chg_elen", 32'(err_len), 32'd0);

      // clr on the end-of-pulse edge.
      do_clr();
      pulse(3'b010, 5);
      pulse(3'b010, 31);
      check("pre_clr_alarm", 32'(alarm_latched), 32'b010);
      buz = 3'b010;
      repeat (31) tick();
      buz = 3'b000;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_ev", 32'(event_valid), 32'd1);
      check("clr_code", 32'(event_code), 32'd2);
      check("clr_alarm", 32'(alarm_latched), 32'd0);
      check("clr_elen", 32'(err_len), 32'd0);
      check("clr_emulti", 32'(err_multi), 32'd0);
      rd(2'd1, v);
      check("clr_cnt1", 32'(v), 32'd0);
      rd(2'd3, v);
      check("clr_total", 32'(v), 32'd0);

      // ena low across a whole pulse.
      len_before = event_len;
      ev_seen = 0;
      ena = 1'b0;
      pulse(3'b001, 31);
      ena = 1'b1;
      repeat (2) tick();
      check("ena_noev", 32'(ev_seen), 32'd0);
      check("ena_len", 32'(event_len), 32'(len_before));
      rd(2'd0, v);
      check("ena_cnt0", 32'(v), 32'd0);

      // Counter saturation.
      do_clr();
      for (int n = 0; n < 260; n++) pulse(3'b100, 31);
      rd(2'd2, v);
      check("sat_cnt2", 32'(v), 32'd255);
      rd(2'd3, v);
      check("sat_total", 32'(v), 32'd255);
      rd(2'd0, v);
      check("sat_cnt0", 32'(v), 32'd0);
      check("sat_alarm", 32'(alarm_latched), 32'b100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarm_pulse_decoder.md
Name: alarm_pulse_decoder

Overview:
- Receive-side decoder for the three one-hot buzzer lines driven by the sensor/buzzer controller; sits on the far end of that interface in the same clock domain.
- Validates each buzzer pulse: exactly one line high, width within PULSE_LEN ± TOL.
- For each valid pulse: emits a one-cycle event, increments a saturating per-channel counter, and latches a per-channel alarm flag.
- Malformed activity sets sticky error flags; counters and flags are read back through a registered select port.

Parameters:
- PULSE_LEN, 31, nominal pulse width in cycles.
- TOL, 1, allowed ± deviation from PULSE_LEN in cycles.
- LEN_W, 6, width of the pulse-length counter.
- CNT_W, 8, width of the event counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  enable; when low all state holds.
- buz  in  3  buzzer lines; bit0 = ch0 … bit2 = ch2.
- clr  in  1  synchronous clear of counters, alarm flags and error flags.
- rd_sel  in  2  readback select.
- rd_data  out  CNT_W  registered readback value.
- event_valid  out  1  one-cycle strobe per valid pulse.
- event_code  out  2  channel+1 of last event (1..3); 0 after reset.
- event_len  out  LEN_W  measured width of last event.
- alarm_latched  out  3  sticky per-channel alarm flags.
- err_multi  out  1  sticky: multi-hot or channel change seen.
- err_len  out  1  sticky: pulse width out of tolerance.

Behaviour:
- Reset (async): every output = 0, all counters = 0, FSM = WAIT_LOW.
- ena=0: FSM, len and counters hold; event_valid forced to 0; clr ignored; rd_data holds.
- FSM states are IDLE, MEASURE and WAIT_LOW; buz is sampled on every enabled edge.
- IDLE:
  - buz=000: stay.
  - one-hot buz: go to MEASURE; ch = index of the high bit; len = 1.
  - any other value: set err_multi; go to WAIT_LOW.
- MEASURE:
  - buz equals onehot(ch): len increments, saturating at 2^LEN_W-1.
  - buz=000: pulse ends; go to IDLE.
    - If PULSE_LEN-TOL ≤ len ≤ PULSE_LEN+TOL: during the following cycle event_valid=1, event_code=ch+1, event_len=len; cnt[ch] +1 (saturating at 2^CNT_W-1); total +1 (saturating); alarm_latched[ch]=1.
    - Otherwise: set err_len; no event.
  - any other value: set err_multi; go to WAIT_LOW; no event.
- WAIT_LOW: on buz=000 go to IDLE; sets no flags. Because reset enters WAIT_LOW, a pulse already in progress at reset release is discarded silently.
- Latency: event_valid is high exactly in the cycle after the first sampled-low cycle. Back-to-back pulses need ≥1 low cycle between them; that low cycle is the end-of-pulse cycle.
- clr=1:
  - Clears cnt[0..2], total, alarm_latched, err_multi and err_len on that edge.
  - Has priority over an increment or flag set on the same edge.
  - event_valid, event_code and event_len are still produced; the FSM is unaffected.
- rd_data, registered with 1-cycle latency from rd_sel:
  - rd_sel 0..2 → cnt[rd_sel].
  - rd_sel 3 → total valid events.
  - Reflects counter values before the current edge's update.
- Saturation: counters stick at their maximum value and never wrap. A len saturated at max is compared as-is and fails tolerance unless it is within range.

Test Plan:
- Assert rst_n=0 mid-operation → all outputs 0 immediately. Release while buz=010 held 10 more cycles → no event, err_len=0, err_multi=0.
- Pulse buz=010 for 31 cycles, then 000 → event_valid high for exactly 1 cycle, one cycle after the first low sample, with event_code=2 and event_len=31. alarm_latched=010; rd_sel=1 gives rd_data=1 next cycle.
- Pulse buz=001 for 20 cycles, then for 32 cycles → first pulse: err_len=1, no event. Second pulse: event, code=1, len=32, cnt0=1.
- From IDLE drive buz=011 for 5 cycles, then 000, then a valid 31-cycle 100 pulse → err_multi=1 and no event for 011; second pulse gives event code=3, cnt2=1. Repeat with 001 switching to 100 mid-pulse → err_multi, no event.
- 260 valid ch2 pulses with CNT_W=8 → cnt2=255; total (rd_sel=3) = 255; no wrap.
- Assert clr on the edge where a valid pulse ends → event_valid still pulses with code correct; all counters, alarm_latched and errors = 0 afterwards. ena=0 across an entire pulse → no event and len unchanged.
